// File: rtl/hwpf_req_queue.sv
// hwpf_req_queue - deduplicating prefetch request queue.
//
// Accepts up to INSERTS line-address candidates per cycle, filters same-cycle
// duplicates (highest port wins) and duplicates of queued entries (move-to-tail
// with the new tag), and presents the oldest entry to the dcache arbiter.
// Storage is a compacting shift queue with index 0 as the head.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   flush_i                clear all entries (inserts/pop ignored that cycle)
//   lock_i                 ignore insert ports; pop still served
//   ins_valid_i/addr_i/tag_i  per-port insert requests (flattened)
//   ins_hit_o              per-port duplicate indication (combinational)
//   req_valid_o/addr_o/tag_o  head entry, zero when empty
//   req_ready_i            arbiter consumes head
//   occupancy_o            registered entry count
//   drop_cnt_o             saturating count of dropped/evicted requests

// Per-port comparator against every queued entry.
module hwpf_req_queue_lane #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 58
) (
  input  logic                         act,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DEPTH-1:0]             ent_vld,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  output logic [DEPTH-1:0]             match
);
  always_comb begin
    for (int e = 0; e < DEPTH; e++)
      match[e] = act & ent_vld[e] & (ent_addr[e] == addr);
  end
endmodule

module hwpf_req_queue #(
  parameter int DEPTH       = 8,
  parameter int INSERTS     = 2,
  parameter int ADDR_W      = 58,
  parameter int TAG_W       = 8,
  parameter int DROP_OLDEST = 0,
  parameter int CNT_W       = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         lock_i,
  input  logic [INSERTS-1:0]           ins_valid_i,
  input  logic [INSERTS*ADDR_W-1:0]    ins_addr_i,
  input  logic [INSERTS*TAG_W-1:0]     ins_tag_i,
  output logic [INSERTS-1:0]           ins_hit_o,
  output logic                         req_valid_o,
  output logic [ADDR_W-1:0]            req_addr_o,
  output logic [TAG_W-1:0]             req_tag_o,
  input  logic                         req_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic [CNT_W-1:0]             drop_cnt_o
);
  localparam int OW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } ins_t;

  ins_t [INSERTS-1:0]            ins;
  logic [INSERTS-1:0]            act, same_dup, surv, qhit, refr, newr;
  logic [INSERTS-1:0][DEPTH-1:0] match;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_q, addr_d;
  logic [DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [DEPTH-1:0]              vld, remove;
  logic [OW-1:0]                 cnt_q, cnt_d;
  logic [CNT_W-1:0]              drop_q;
  logic [CNT_W:0]                drop_sum;
  logic                          pop;
  int n_keep, n_ref, n_new, n_acc, evict, dropped, k, slot, a;

  // Queue is compacted, so entry e is valid iff e < count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    assign vld[g] = (cnt_q > OW'(g));
  end

  always_comb begin
    for (int p = 0; p < INSERTS; p++) begin
      ins[p].addr = ins_addr_i[p*ADDR_W +: ADDR_W];
      ins[p].tag  = ins_tag_i[p*TAG_W +: TAG_W];
      act[p]      = ins_valid_i[p] & ~lock_i & ~flush_i;
    end
  end

  // A port loses to any higher-index active port with the same address.
  always_comb begin
    same_dup = '0;
    for (int p = 0; p < INSERTS; p++)
      for (int q = p + 1; q < INSERTS; q++)
        if (act[p] && act[q] && (ins[q].addr == ins[p].addr)) same_dup[p] = 1'b1;
  end

  assign surv = act & ~same_dup;

  for (genvar p = 0; p < INSERTS; p++) begin : g_lane
    hwpf_req_queue_lane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
      .act      (surv[p]),
      .addr     (ins[p].addr),
      .ent_vld  (vld),
      .ent_addr (addr_q),
      .match    (match[p])
    );
  end

  always_comb begin
    pop    = vld[0] & req_ready_i & ~flush_i;
    remove = '0;
    remove[0] = pop;
    n_ref  = 0;
    n_new  = 0;
    for (int p = 0; p < INSERTS; p++) begin
      qhit[p] = |match[p];
      // A hit on the head being popped is satisfied by the pop itself.
      refr[p] = qhit[p] & ~(match[p][0] & pop);
      newr[p] = surv[p] & ~qhit[p];
      if (refr[p]) begin
        remove = remove | match[p];
        n_ref++;
      end
      if (newr[p]) n_new++;
    end

    n_keep = 0;
    for (int e = 0; e < DEPTH; e++)
      if (vld[e] && !remove[e]) n_keep++;

    // Refreshes always fit: each one freed the slot it came from.
    if (DROP_OLDEST != 0) begin
      evict = n_keep + n_ref + n_new - DEPTH;
      if (evict < 0) evict = 0;
      n_acc   = n_new;
      dropped = evict;
    end else begin
      evict = 0;
      n_acc = DEPTH - n_keep - n_ref;
      if (n_acc > n_new) n_acc = n_new;
      dropped = n_new - n_acc;
    end

    addr_d = '0;
    tag_d  = '0;
    k      = 0;
    for (int e = 0; e < DEPTH; e++) begin
      if (vld[e] && !remove[e]) begin
        if (k >= evict) begin
          addr_d[IW'(k - evict)] = addr_q[e];
          tag_d[IW'(k - evict)]  = tag_q[e];
        end
        k++;
      end
    end

    slot = n_keep - evict;
    for (int p = 0; p < INSERTS; p++) begin
      if (refr[p]) begin
        addr_d[IW'(slot)] = ins[p].addr;
        tag_d[IW'(slot)]  = ins[p].tag;
        slot++;
      end
    end
    // Lowest ports are accepted first when space runs out.
    a = 0;
    for (int p = 0; p < INSERTS; p++) begin
      if (newr[p]) begin
        if (a < n_acc) begin
          addr_d[IW'(slot)] = ins[p].addr;
          tag_d[IW'(slot)]  = ins[p].tag;
          slot++;
        end
        a++;
      end
    end
    cnt_d = OW'(slot);
  end

  assign drop_sum = {1'b0, drop_q} + DW'(unsigned'(dropped));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      addr_q <= '0;
      tag_q  <= '0;
      drop_q <= '0;
    end else if (flush_i) begin
      cnt_q  <= '0;
      addr_q <= '0;
      tag_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      tag_q  <= tag_d;
      drop_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  assign ins_hit_o   = same_dup | qhit;
  assign req_valid_o = vld[0];
  assign req_addr_o  = addr_q[0];
  assign req_tag_o   = tag_q[0];
  assign occupancy_o = cnt_q;
  assign drop_cnt_o  = drop_q;
endmodule
